// File: rtl/stage_wb_pipe_pkg.sv
// Shared encodings for the writeback stage: writeback source select,
// load funct3 codes and the slot FSM states.
package stage_wb_pipe_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_PC4  = 2'b10,
    WB_SEL_IMM  = 2'b11
  } wb_sel_e;

  localparam logic [2:0] LOAD_F3_LB  = 3'b000;
  localparam logic [2:0] LOAD_F3_LH  = 3'b001;
  localparam logic [2:0] LOAD_F3_LW  = 3'b010;
  localparam logic [2:0] LOAD_F3_LD  = 3'b011;
  localparam logic [2:0] LOAD_F3_LBU = 3'b100;
  localparam logic [2:0] LOAD_F3_LHU = 3'b101;
  localparam logic [2:0] LOAD_F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FULL,
    ST_WAIT_LOAD
  } wb_state_e;

endpackage

// File: rtl/stage_wb_pipe_if.sv
// MEM -> WB handoff bundle. The MEM stage is the master; the writeback
// stage is the slave and returns mem_ready.
interface stage_wb_pipe_if #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      mem_valid;
  logic                      mem_ready;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
  logic                      mem_reg_write_en;
  logic [1:0]                mem_wb_sel;
  logic [2:0]                mem_funct3;
  logic [REG_WIDTH-1:0]      mem_alu_out;
  logic [REG_WIDTH-1:0]      mem_pc_plus4;
  logic [REG_WIDTH-1:0]      mem_imm;

  modport master (
    output mem_valid, mem_rd_addr, mem_reg_write_en, mem_wb_sel,
           mem_funct3, mem_alu_out, mem_pc_plus4, mem_imm,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_rd_addr, mem_reg_write_en, mem_wb_sel,
           mem_funct3, mem_alu_out, mem_pc_plus4, mem_imm,
    output mem_ready
  );
endinterface

// File: rtl/stage_wb_pipe_load_align_ext.sv
// Load data alignment and sign/zero extension for 32- or 64-bit datapaths.
// Raw data is a naturally aligned word/dword; offset selects the lane.
module load_align_ext
  import stage_wb_pipe_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  localparam int OFF_W    = $clog2(REG_WIDTH / 8)
) (
  input  logic [REG_WIDTH-1:0] raw_data,
  input  logic [OFF_W-1:0]     offset,
  input  logic [2:0]           funct3,
  output logic [REG_WIDTH-1:0] ext_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  always_comb begin
    byte_v = 8'(raw_data >> {offset, 3'b000});
    half_v = 16'(raw_data >> {offset[OFF_W-1:1], 4'b0000});
    // Top offset bit picks the word lane; only meaningful when REG_WIDTH is 64.
    word_v = 32'(raw_data >> {offset[OFF_W-1], 5'b00000});

    ext_data = raw_data;
    case (funct3)
      LOAD_F3_LB: begin
        ext_data      = {REG_WIDTH{byte_v[7]}};
        ext_data[7:0] = byte_v;
      end
      LOAD_F3_LBU: begin
        ext_data      = '0;
        ext_data[7:0] = byte_v;
      end
      LOAD_F3_LH: begin
        ext_data       = {REG_WIDTH{half_v[15]}};
        ext_data[15:0] = half_v;
      end
      LOAD_F3_LHU: begin
        ext_data       = '0;
        ext_data[15:0] = half_v;
      end
      LOAD_F3_LW: begin
        if (REG_WIDTH == 64) begin
          ext_data       = {REG_WIDTH{word_v[31]}};
          ext_data[31:0] = word_v;
        end
      end
      LOAD_F3_LWU: begin
        if (REG_WIDTH == 64) begin
          ext_data       = '0;
          ext_data[31:0] = word_v;
        end
      end
      LOAD_F3_LD: ext_data = raw_data;
      default:    ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/stage_wb_pipe.sv
// Writeback stage: MEM/WB slot with variable-latency load wait and timeout,
// driving the register-file write port and retire/error indications.
module stage_wb_pipe
  import stage_wb_pipe_pkg::*;
#(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_TIMEOUT   = 15,
  parameter int TMO_CNT_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  stage_wb_pipe_if.slave            mem,
  input  logic [REG_WIDTH-1:0]      dmem_rdata,
  input  logic                      dmem_rvalid,
  output logic                      wb_reg_write_en,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  output logic [REG_WIDTH-1:0]      wb_data,
  output logic                      wb_retire,
  output logic                      wb_load_err
);

  localparam int OFF_W = $clog2(REG_WIDTH / 8);
  localparam logic [TMO_CNT_WIDTH-1:0] TMO_LAST = TMO_CNT_WIDTH'(LOAD_TIMEOUT - 1);

  wb_state_e                 state;
  logic [TMO_CNT_WIDTH-1:0]  tmo_cnt;
  logic [REG_ADDR_WIDTH-1:0] slot_rd;
  logic                      slot_we;
  wb_sel_e                   slot_sel;
  logic [2:0]                slot_f3;
  logic [REG_WIDTH-1:0]      slot_alu;
  logic [REG_WIDTH-1:0]      slot_pc4;
  logic [REG_WIDTH-1:0]      slot_imm;

  logic                      slot_valid;
  logic                      load_done;
  logic                      timeout;
  logic                      retire;
  logic [REG_WIDTH-1:0]      load_data;
  logic [REG_WIDTH-1:0]      sel_data;

  load_align_ext #(
    .REG_WIDTH (REG_WIDTH)
  ) u_load_align_ext (
    .raw_data (dmem_rdata),
    .offset   (slot_alu[OFF_W-1:0]),
    .funct3   (slot_f3),
    .ext_data (load_data)
  );

  always_comb begin
    slot_valid = (state != ST_EMPTY);
    load_done  = (state == ST_WAIT_LOAD) && dmem_rvalid;
    timeout    = (state == ST_WAIT_LOAD) && !dmem_rvalid && (tmo_cnt == TMO_LAST);
    retire     = !flush && ((state == ST_FULL) || load_done || timeout);

    case (slot_sel)
      WB_SEL_ALU:  sel_data = slot_alu;
      WB_SEL_LOAD: sel_data = load_data;
      WB_SEL_PC4:  sel_data = slot_pc4;
      WB_SEL_IMM:  sel_data = slot_imm;
      default:     sel_data = slot_alu;
    endcase
  end

  always_comb begin
    mem.mem_ready   = !reset && ((state == ST_EMPTY) || retire);
    wb_retire       = !reset && retire;
    wb_load_err     = !reset && !flush && timeout;
    wb_reg_write_en = !reset && !flush && ((state == ST_FULL) || load_done) &&
                      slot_we && (slot_rd != '0);
    wb_rd_addr      = (!reset && slot_valid) ? slot_rd : '0;
    wb_data         = (!reset && slot_valid) ? sel_data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      tmo_cnt  <= '0;
      slot_rd  <= '0;
      slot_we  <= 1'b0;
      slot_sel <= WB_SEL_ALU;
      slot_f3  <= '0;
      slot_alu <= '0;
      slot_pc4 <= '0;
      slot_imm <= '0;
    end else if (flush) begin
      state   <= ST_EMPTY;
      tmo_cnt <= '0;
    end else if ((state == ST_EMPTY) || retire) begin
      // Slot is free this cycle (mem_ready high), so a valid input is captured.
      tmo_cnt <= '0;
      if (mem.mem_valid) begin
        slot_rd  <= mem.mem_rd_addr;
        slot_we  <= mem.mem_reg_write_en;
        slot_sel <= wb_sel_e'(mem.mem_wb_sel);
        slot_f3  <= mem.mem_funct3;
        slot_alu <= mem.mem_alu_out;
        slot_pc4 <= mem.mem_pc_plus4;
        slot_imm <= mem.mem_imm;
        state    <= (wb_sel_e'(mem.mem_wb_sel) == WB_SEL_LOAD) ? ST_WAIT_LOAD : ST_FULL;
      end else begin
        state <= ST_EMPTY;
      end
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: doc/stage_wb_pipe.md
Name: stage_wb_pipe

Overview:
Parametrised writeback stage that owns the MEM/WB pipeline register and a one-entry holding slot. It selects the writeback source from ALU result, aligned and sign/zero-extended load data, PC+4 or immediate. It waits on a variable-latency data-memory response, with a timeout, and drives the register-file write port plus a forwarding view. Sits between the MEM stage and the register file; successor to the fixed two-input combinational WB mux.

Parameters:
REG_WIDTH, 32, datapath width; 32 or 64 only.
REG_ADDR_WIDTH, 5, destination register index width.
LOAD_TIMEOUT, 15, max cycles waiting for dmem_rvalid before abandoning a load; must be >=1.
TMO_CNT_WIDTH, 4, width of the timeout counter; must hold LOAD_TIMEOUT.

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  synchronous, active-high
flush  in  1  kill the held instruction and any incoming one
mem_valid  in  1  MEM stage presents an instruction
mem_ready  out  1  stage accepts the instruction this cycle
mem_rd_addr  in  REG_ADDR_WIDTH  destination register
mem_reg_write_en  in  1  instruction writes rd
mem_wb_sel  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 IMM
mem_funct3  in  3  load type
mem_alu_out  in  REG_WIDTH  ALU result / load address
mem_pc_plus4  in  REG_WIDTH  link value
mem_imm  in  REG_WIDTH  immediate (LUI)
dmem_rdata  in  REG_WIDTH  raw load data, naturally aligned word/dword
dmem_rvalid  in  1  dmem_rdata valid this cycle
wb_reg_write_en  out  1  register-file write strobe
wb_rd_addr  out  REG_ADDR_WIDTH  write index
wb_data  out  REG_WIDTH  write data
wb_retire  out  1  instruction retires this cycle, with or without a write
wb_load_err  out  1  one-cycle pulse on load timeout

Behaviour:
- FSM states: EMPTY, FULL, WAIT_LOAD. Reset -> EMPTY, timeout counter 0, slot fields 0. All outputs 0 during and after reset until a capture occurs; mem_ready=1 in EMPTY.
- Capture: slot loads all mem_* fields at the edge where mem_valid && mem_ready && !flush. Next state is WAIT_LOAD if sel=LOAD, otherwise FULL. Latency: MEM handoff to register-file write is 1 cycle minimum.
- FULL: retires the same cycle. wb_retire=1. wb_reg_write_en = we && rd!=0.
- WAIT_LOAD without dmem_rvalid: counter increments. No write, wb_retire=0, mem_ready=0.
- WAIT_LOAD with dmem_rvalid: completes combinationally in that cycle. Extended data is driven on wb_data, write as in FULL, counter cleared.
- Timeout: counter reaches LOAD_TIMEOUT without rvalid -> that cycle wb_load_err=1 and wb_retire=1. No write. Slot retires, counter cleared.
- mem_ready = (state==EMPTY) || retiring this cycle. This gives back-to-back throughput of 1/cycle; a new capture in a retiring cycle is legal.
- Next state after retire: capture target if a new instruction is accepted, else EMPTY.
- dmem_rvalid outside WAIT_LOAD is ignored.
- flush: highest priority after reset. Held slot is discarded with no write, no retire, no err. The incoming instruction is not captured. State -> EMPTY, counter cleared. A flush in the same cycle as rvalid also suppresses the write.
- Load extension, offset = mem_alu_out[log2(REG_WIDTH/8)-1:0]:
  - LB/LBU (000/100): byte at offset, sign-/zero-extended.
  - LH/LHU (001/101): halfword at offset with bit 0 ignored.
  - LW (010): word at offset[2] when REG_WIDTH=64, sign-extended.
  - LWU (110): zero-extended, 64-bit only.
  - LD (011): full dword, 64-bit only.
  - Any other code: full REG_WIDTH passthrough.
- wb_data is driven with the selected source whenever the slot is valid, else 0. rd=0 never asserts wb_reg_write_en.

Decomposition:
- risc_v_defines gains WB_SEL_* encodings, LOAD_F3_* codes and the FSM state encoding.
- One sub-module, load_align_ext: combinational, parametrised by REG_WIDTH. Inputs raw data, offset, funct3; output extended value.
- FSM, slot register and timeout counter stay in stage_wb_pipe.

Test Plan:
- ALU op: rd=5, sel=00, alu=0x1234 -> next cycle wb_reg_write_en=1, rd 5, data 0x00001234, retire=1; mem_ready stays 1.
- LB at alu=0x1003, rvalid 3 cycles later with rdata 0x80FF_0000 -> mem_ready=0 for 3 cycles, then write 0xFFFFFF80. LBU with the same stimulus -> 0x00000080.
- Back-to-back: 4 ALU ops on consecutive cycles to rd 1..4 -> 4 consecutive writes, no bubbles. rd=0 op -> retire=1, wb_reg_write_en=0.
- Timeout: load with no rvalid -> wb_load_err pulses on cycle LOAD_TIMEOUT after capture, no write. A late rvalid afterwards is ignored.
- flush during WAIT_LOAD, coincident with rvalid -> no write, no retire, state EMPTY. A following ALU op captured next cycle writes normally.
- REG_WIDTH=64: LW at offset 4 with rdata 0x8000_0001_xxxx_xxxx -> 0xFFFFFFFF80000001. Reset asserted mid-WAIT_LOAD -> outputs 0, mem_ready=1 on the next cycle.
